// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
// Looked up combinationally with fetch's next PC; trained by execute-stage branch resolution.
module branch_predictor #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 16 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] lookup_pc,
  output logic [15:0] target_bp,
  output logic        target_en_bp,
  input  logic        update_en,
  input  logic [15:0] update_pc,
  input  logic        update_taken,
  input  logic [15:0] update_target,
  input  logic        update_pred_taken,
  input  logic [15:0] update_pred_target,
  output logic        mispredict,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    sat_inc = (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    sat_dec = (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [15:0]         target_q [ENTRIES];
  logic [15:0]         target_d [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [1:0]          ctr_d    [ENTRIES];
  logic                mispredict_q, mispredict_d;
  logic [15:0]         branch_count_q, branch_count_d;
  logic [15:0]         mispredict_count_q, mispredict_count_d;

  logic [INDEX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0]   lk_tag, up_tag;
  logic                  lk_hit, up_hit, up_mp;

  assign lk_idx = lookup_pc[INDEX_BITS-1:0];
  assign lk_tag = lookup_pc[15:INDEX_BITS];
  assign up_idx = update_pc[INDEX_BITS-1:0];
  assign up_tag = update_pc[15:INDEX_BITS];

  // Zero-latency prediction from the pre-update table contents (no bypass).
  always_comb begin
    lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    target_en_bp = lk_hit && ctr_q[lk_idx][1];
    if (target_en_bp) begin
      target_bp = target_q[lk_idx];
    end else begin
      target_bp = 16'h0000;
    end
  end

  // Training, mispredict detection and saturating statistics; reset overrides any update.
  always_comb begin
    valid_d            = valid_q;
    tag_d              = tag_q;
    target_d           = target_q;
    ctr_d              = ctr_q;
    mispredict_d       = 1'b0;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_mp  = (update_pred_taken != update_taken) ||
             (update_taken && update_pred_taken && (update_pred_target != update_target));
    if (reset) begin
      valid_d = '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_d[i] = 2'b01;
      end
      branch_count_d     = 16'h0000;
      mispredict_count_d = 16'h0000;
    end else if (update_en) begin
      if (up_hit) begin
        if (update_taken) begin
          ctr_d[up_idx]    = sat_inc(ctr_q[up_idx]);
          target_d[up_idx] = update_target;
        end else begin
          ctr_d[up_idx] = sat_dec(ctr_q[up_idx]);
        end
      end else if (update_taken) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = update_target;
        ctr_d[up_idx]    = 2'b10;
      end else begin
        valid_d = valid_q;
      end
      mispredict_d = up_mp;
      if (branch_count_q != 16'hFFFF) begin
        branch_count_d = branch_count_q + 16'd1;
      end else begin
        branch_count_d = branch_count_q;
      end
      if (up_mp && (mispredict_count_q != 16'hFFFF)) begin
        mispredict_count_d = mispredict_count_q + 16'd1;
      end else begin
        mispredict_count_d = mispredict_count_q;
      end
    end else begin
      mispredict_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    valid_q            <= valid_d;
    tag_q              <= tag_d;
    target_q           <= target_d;
    ctr_q              <= ctr_d;
    mispredict_q       <= mispredict_d;
    branch_count_q     <= branch_count_d;
    mispredict_count_q <= mispredict_count_d;
  end

  assign mispredict       = mispredict_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule
